// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time
// and hands the fetched word to decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] fetch_pc,
  input  logic [31:0] pc_plus_4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misaligned_error
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_d;
  logic [31:0] data_d;
  logic [31:0] ipc_d;
  logic        err_d;
  logic        req_fire;

  assign fetch_pc       = pc_q;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = (state_q == S_FETCH) && !reset;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = inst_valid;
    data_d  = inst_data;
    ipc_d   = inst_pc;
    err_d   = misaligned_error;

    unique case (state_q)
      S_FETCH: begin
        if (req_fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          data_d  = imem_resp_data;
          ipc_d   = pc_q;
          pc_d    = pc_plus_4;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_resp_valid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A redirect squashes any capture from this cycle's response.
    if (redirect_valid) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      valid_d = 1'b0;
      data_d  = inst_data;
      ipc_d   = inst_pc;
      if (|redirect_target[1:0]) err_d = 1'b1;
      unique case (state_q)
        S_FETCH: state_d = req_fire ? S_DRAIN : S_FETCH;
        S_WAIT:  state_d = imem_resp_valid ? S_FETCH : S_DRAIN;
        S_HOLD:  state_d = S_FETCH;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_FETCH;
      pc_q             <= RESET_PC;
      inst_valid       <= 1'b0;
      inst_data        <= 32'h0;
      inst_pc          <= 32'h0;
      misaligned_error <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inst_valid       <= valid_d;
      inst_data        <= data_d;
      inst_pc          <= ipc_d;
      misaligned_error <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: small latency-programmable imem model
// plus hand-computed expectations for each scenario.
module tb_fetch_unit;

  localparam logic [31:0] RST = 32'h0040_0000;

  logic        clock;
  logic        reset;
  logic [31:0] fetch_pc;
  logic [31:0] pc_plus_4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        misaligned_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] maddr = 32'h0;

  fetch_unit #(.RESET_PC(RST)) dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_pc        (fetch_pc),
    .pc_plus_4       (pc_plus_4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .misaligned_error(misaligned_error)
  );

  // Shared adder stand-in
  assign pc_plus_4 = fetch_pc + 32'd4;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory: response mem_lat cycles after the cycle following acceptance
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (imem_resp_valid) pend = 1'b0;
        else if (pend && cnt > 0) cnt--;
        if (imem_req_valid && imem_req_ready) begin
          pend  = 1'b1;
          cnt   = mem_lat;
          maddr = imem_req_addr;
        end
      end
      #1;
      imem_resp_valid = pend && (cnt == 0);
      imem_resp_data  = ~maddr;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int c);
    c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (inst_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("wait_valid", {31'd0, inst_valid}, 32'd1);
  endtask

  initial begin
    int c;
    int prev;
    reset           = 1'b1;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_req_ready  = 1'b1;

    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
      check("rst_pc", fetch_pc, RST);
      check("rst_req", {31'd0, imem_req_valid}, 32'd0);
    end
    reset = 1'b0;
    #1;
    check("post_req", {31'd0, imem_req_valid}, 32'd1);
    check("post_addr", imem_req_addr, RST);
    check("post_ivalid", {31'd0, inst_valid}, 32'd0);
    check("post_err", {31'd0, misaligned_error}, 32'd0);

    // Sequential fetch
    inst_ready = 1'b1;
    prev = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_valid(c);
      check("seq_pc", inst_pc, RST + 32'(4 * i));
      check("seq_data", inst_data, ~(RST + 32'(4 * i)));
      check("seq_gap", 32'(c - prev), (i == 0) ? 32'd2 : 32'd3);
      prev = c;
    end

    // Backpressure
    wait_valid(c);
    inst_ready = 1'b0;
    check("bp_pc0", inst_pc, RST + 32'h10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("bp_valid", {31'd0, inst_valid}, 32'd1);
      check("bp_pc", inst_pc, RST + 32'h10);
      check("bp_data", inst_data, ~(RST + 32'h10));
      check("bp_req", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    @(negedge clock);
    check("bp_rel_req", {31'd0, imem_req_valid}, 32'd1);
    check("bp_rel_addr", imem_req_addr, RST + 32'h14);
    check("bp_rel_iv", {31'd0, inst_valid}, 32'd0);

    // Redirect in FETCH without acceptance
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0040_0008;
    @(negedge clock);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = 2;
    check("rf_req", {31'd0, imem_req_valid}, 32'd1);
    check("rf_addr", imem_req_addr, 32'h0040_0008);

    // Redirect in WAIT, response two cycles later
    @(negedge clock);
    check("rw_wait_req", {31'd0, imem_req_valid}, 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0040_0100;
    @(negedge clock);
    redirect_valid = 1'b0;
    mem_lat        = 0;
    check("rw_pc", fetch_pc, 32'h0040_0100);
    check("rw_drain_req", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clock);
    check("rw_resp_iv", {31'd0, inst_valid}, 32'd0);
    check("rw_resp_req", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clock);
    check("rw_iv", {31'd0, inst_valid}, 32'd0);
    check("rw_req", {31'd0, imem_req_valid}, 32'd1);
    check("rw_addr", imem_req_addr, 32'h0040_0100);
    @(negedge clock);
    @(negedge clock);
    check("rw_ivalid", {31'd0, inst_valid}, 32'd1);
    check("rw_ipc", inst_pc, 32'h0040_0100);
    check("rw_idata", inst_data, ~32'h0040_0100);

    // Redirect in HOLD
    inst_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    @(negedge clock);
    check("rh_iv", {31'd0, inst_valid}, 32'd0);
    check("rh_req", {31'd0, imem_req_valid}, 32'd1);
    check("rh_addr", imem_req_addr, 32'h0000_0200);

    // Misaligned redirect while the request is accepted
    redirect_target = 32'h0040_0102;
    @(negedge clock);
    redirect_valid = 1'b0;
    check("mis_err", {31'd0, misaligned_error}, 32'd1);
    check("mis_req", {31'd0, imem_req_valid}, 32'd0);
    check("mis_pc", fetch_pc, 32'h0040_0100);
    @(negedge clock);
    inst_ready = 1'b1;
    check("mis_req2", {31'd0, imem_req_valid}, 32'd1);
    check("mis_addr", imem_req_addr, 32'h0040_0100);
    check("mis_sticky", {31'd0, misaligned_error}, 32'd1);
    check("mis_iv", {31'd0, inst_valid}, 32'd0);

    // Wrap-around
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    check("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_err", {31'd0, misaligned_error}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("wrap_iv", {31'd0, inst_valid}, 32'd1);
    check("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_data", inst_data, 32'h0000_0003);
    @(negedge clock);
    check("wrap_req", {31'd0, imem_req_valid}, 32'd1);
    check("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Reset clears the sticky flag
    reset = 1'b1;
    @(negedge clock);
    check("rst2_err", {31'd0, misaligned_error}, 32'd0);
    check("rst2_iv", {31'd0, inst_valid}, 32'd0);
    check("rst2_pc", fetch_pc, RST);
    check("rst2_req", {31'd0, imem_req_valid}, 32'd0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the multicycle RISC-V core. Holds the architectural PC, issues one instruction-memory read at a time, and presents the fetched word with its PC to decode over a valid/ready handshake. The sequential next PC comes from the shared `adder` instance: `fetch_pc` drives its `operand_a`, the constant 4 drives its `operand_b`, and its `result` returns as `pc_plus_4`. Branch and jump targets from execute arrive through the redirect port.

## Interface
Parameters:
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_pc`  out  32  current PC register; drives adder `operand_a`.
- `pc_plus_4`  in  32  adder `result` (`fetch_pc + 4`).
- `redirect_valid`  in  1  load `redirect_target` into the PC.
- `redirect_target`  in  32  branch/jump target.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_addr`  out  32  read address; always equals `fetch_pc`.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_resp_valid`  in  1  read data valid; at most one per accepted request.
- `imem_resp_data`  in  32  read data.
- `inst_valid`  out  1  fetched instruction available.
- `inst_data`  out  32  fetched instruction.
- `inst_pc`  out  32  PC of `inst_data`.
- `inst_ready`  in  1  decode accepts the instruction.
- `misaligned_error`  out  1  sticky flag; a redirect target had bits [1:0] != 0.

## Operation
- **States:**
  - FETCH: request issued.
  - WAIT: request accepted, awaiting response.
  - HOLD: instruction buffered.
  - DRAIN: awaiting a response to discard.
- **Reset:** state FETCH, PC = `RESET_PC`, `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0, `misaligned_error` = 0.
- **Request valid:** `imem_req_valid` = (state == FETCH) && !reset. It depends on no other input.
- **FETCH:**
  - `imem_req_valid` & `imem_req_ready` -> WAIT.
  - PC is unchanged while the request is outstanding.
- **WAIT:**
  - On `imem_resp_valid`: `inst_data` <= `imem_resp_data`, `inst_pc` <= PC, PC <= `pc_plus_4`, `inst_valid` <= 1, go to HOLD.
- **HOLD:**
  - Outputs are held stable.
  - `inst_valid` & `inst_ready` -> `inst_valid` <= 0, go to FETCH.
- **Redirect (highest priority after reset):** PC <= {`redirect_target`[31:2], 2'b00}. If `redirect_target`[1:0] != 0, then `misaligned_error` <= 1; it clears only on reset. Next state by current state:
  - FETCH, request accepted the same cycle: DRAIN.
  - FETCH, no acceptance: stay in FETCH; the next request uses the new PC.
  - WAIT, `imem_resp_valid` the same cycle: discard the response, go to FETCH.
  - WAIT, otherwise: DRAIN.
  - DRAIN: stay in DRAIN; PC is updated only.
  - HOLD: `inst_valid` <= 0, go to FETCH. If `inst_ready` is high the same cycle, the handshake still counts as completed.
- **DRAIN:** on `imem_resp_valid`, discard the data, go to FETCH. `inst_*` outputs are never updated from a drained response.
- **Unexpected responses:** `imem_resp_valid` in FETCH or HOLD is a protocol violation. It is ignored and leaves no state change.
- **PC arithmetic:** 32-bit wrap-around; 0xFFFF_FFFC + 4 = 0x0000_0000. There is no overflow flag.

## Timing
- All outputs except `imem_req_valid` and `imem_req_addr` are registered. Those two are decoded from the state and PC registers, with `imem_req_valid` additionally gated by `reset`.
- **Zero-wait memory:** request accepted in cycle T, response in T+1, `inst_valid` high in T+2. With `inst_ready` high in T+2, the next request issues in T+3. Throughput is 1 instruction per 3 cycles.
- **Redirect:** takes effect on the next edge. The first request to the target can issue in the next cycle from FETCH or HOLD, or in the cycle after the drained response from WAIT/DRAIN.
- **Reset mid-operation:** the outstanding request is abandoned. The memory is reset by the same `reset`, so no stale response follows.

## Test plan
- **Reset:**
  - Stimulus: `reset` high for 2 cycles, then low.
  - Required: `fetch_pc` = 0x0040_0000 and `imem_req_valid` = 0 while reset is high; in the first cycle after, `imem_req_valid` = 1 and `imem_req_addr` = 0x0040_0000; `inst_valid` = 0 and `misaligned_error` = 0.
- **Sequential fetch:**
  - Stimulus: zero-wait memory returning data = ~addr; `inst_ready` tied high.
  - Required: `inst_pc` = 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C, each with `inst_data` = ~`inst_pc`, spaced exactly 3 cycles apart.
- **Backpressure:**
  - Stimulus: `inst_ready` = 0 for 5 cycles after `inst_valid` rises.
  - Required: `inst_valid`, `inst_data` and `inst_pc` are stable; `imem_req_valid` = 0 throughout; the next request issues the cycle after `inst_ready` is raised.
- **Redirect in WAIT:**
  - Stimulus: request to 0x0040_0008 accepted; `redirect_valid` with target 0x0040_0100 the next cycle; response arrives 2 cycles later.
  - Required: response discarded with no `inst_valid`; the next request address is 0x0040_0100; the following `inst_pc` is 0x0040_0100.
- **Redirect in HOLD:**
  - Stimulus: `inst_ready` = 0 and `redirect_valid` with target 0x0000_0200.
  - Required: `inst_valid` = 0 next cycle; the next request address is 0x0000_0200.
- **Misaligned redirect and wrap:**
  - Stimulus (misaligned): redirect target 0x0040_0102.
  - Required: `misaligned_error` = 1 and stays 1; the next request address is 0x0040_0100; a subsequent reset clears the flag.
  - Stimulus (wrap): redirect to 0xFFFF_FFFC.
  - Required: the following request address is 0x0000_0000.
